// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/done handshake, results held from DONE until the next accepted start.
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] q_acc_q, q_acc_d;
    logic [WIDTH-1:0] r_acc_q, r_acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_iter;
    logic [WIDTH-1:0] q_iter;

    // Single WIDTH+1 subtractor; the extra bit keeps divisors with MSB set exact.
    always_comb begin
        r_shift = {r_acc_q[WIDTH-2:0], q_acc_q[WIDTH-1]};
        trial   = {1'b0, r_shift} - {1'b0, divisor_q};
        r_iter  = trial[WIDTH] ? r_shift : trial[WIDTH-1:0];
        q_iter  = {q_acc_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d     = state_q;
        divisor_d   = divisor_q;
        q_acc_d     = q_acc_q;
        r_acc_d     = r_acc_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start) begin
                    if (Divisor != '0) begin
                        state_d   = S_RUN;
                        divisor_d = Divisor;
                        q_acc_d   = Dividend;
                        r_acc_d   = '0;
                        count_d   = CW'(WIDTH);
                    end else begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = Dividend;
                        dbz_d       = 1'b1;
                    end
                end
            end
            S_RUN: begin
                q_acc_d = q_iter;
                r_acc_d = r_iter;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d     = S_DONE;
                    quotient_d  = q_iter;
                    remainder_d = r_iter;
                    dbz_d       = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            divisor_q   <= '0;
            q_acc_q     <= '0;
            r_acc_q     <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            q_acc_q     <= q_acc_d;
            r_acc_q     <= r_acc_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Quotient    = quotient_q;
    assign Remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vector table,
// hand-written multi-cycle corner sequences and randomized pairs vs. / and %.
module tb_seq_restoring_divider;
    localparam int W = 16;

    logic         Clk;
    logic         Reset_n;
    logic         start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         div_by_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .busy        (busy),
        .done        (done),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one divide from a point #1 after a rising edge; returns in the done cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic z, output int lat, output int busy_cnt);
        start    = 1'b1;
        Dividend = a;
        Divisor  = b;
        @(posedge Clk); #1;
        start    = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge Clk); #1;
            lat++;
        end
        q = Quotient;
        r = Remainder;
        z = div_by_zero;
    endtask

    // Reference model computed directly from the arithmetic definition.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    // Full transaction: run, compare, and confirm done is a single-cycle pulse with results held.
    task automatic do_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        logic [W-1:0] q, r;
        logic         z;
        int           lat, bc;
        run_div(a, b, q, r, z, lat, bc);
        $display("%s: %0d / %0d -> Q=%0d R=%0d dbz=%0b lat=%0d busy=%0d", tag, a, b, q, r, z, lat, bc);
        check({tag, ".quotient"}, 32'(q), 32'(eq));
        check({tag, ".remainder"}, 32'(r), 32'(er));
        check({tag, ".dbz"}, 32'(z), 32'(ez));
        check({tag, ".latency"}, 32'(lat), (b == 0) ? 32'd0 : 32'(W));
        check({tag, ".busy_cycles"}, 32'(bc), (b == 0) ? 32'd0 : 32'(W));
        @(posedge Clk); #1;
        check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ".held_q"}, 32'(Quotient), 32'(eq));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [W-1:0] q, r, eq, er, a, b, prev_q;
        logic         z, ez;
        int           lat, bc, done_seen;

        vecs[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,    r: 16'd2,      z: 1'b0};
        vecs[1] = '{a: 16'hFFFF,  b: 16'h8000,   q: 16'd1,     r: 16'h7FFF,   z: 1'b0};
        vecs[2] = '{a: 16'h8000,  b: 16'h8001,   q: 16'd0,     r: 16'h8000,   z: 1'b0};
        vecs[3] = '{a: 16'd5,     b: 16'd0,      q: 16'hFFFF,  r: 16'd5,      z: 1'b1};
        vecs[4] = '{a: 16'd9,     b: 16'd3,      q: 16'd3,     r: 16'd0,      z: 1'b0};
        vecs[5] = '{a: 16'd0,     b: 16'd5,      q: 16'd0,     r: 16'd0,      z: 1'b0};
        vecs[6] = '{a: 16'hFFFF,  b: 16'd1,      q: 16'hFFFF,  r: 16'd0,      z: 1'b0};
        vecs[7] = '{a: 16'd1,     b: 16'hFFFF,   q: 16'd0,     r: 16'd1,      z: 1'b0};
        vecs[8] = '{a: 16'hFFFF,  b: 16'hFFFF,   q: 16'd1,     r: 16'd0,      z: 1'b0};
        vecs[9] = '{a: 16'd0,     b: 16'd0,      q: 16'hFFFF,  r: 16'd0,      z: 1'b1};

        Reset_n  = 1'b0;
        start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.quotient", 32'(Quotient), 32'd0);
        check("reset.remainder", 32'(Remainder), 32'd0);
        check("reset.dbz", 32'(div_by_zero), 32'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
        end

        // Second start during RUN must be ignored; results stay stable while busy.
        prev_q   = Quotient;
        start    = 1'b1;
        Dividend = 16'hFFFF;
        Divisor  = 16'd1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge Clk); #1;
        end
        start    = 1'b1;
        Dividend = 16'd10;
        Divisor  = 16'd3;
        check("ignore.stable_while_busy", 32'(Quotient), 32'(prev_q));
        @(posedge Clk); #1;
        start     = 1'b0;
        done_seen = 0;
        q         = '0;
        r         = '1;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                done_seen++;
                q = Quotient;
                r = Remainder;
            end
            @(posedge Clk); #1;
        end
        $display("ignore: Q=0x%0h R=0x%0h done_pulses=%0d", q, r, done_seen);
        check("ignore.done_count", 32'(done_seen), 32'd1);
        check("ignore.quotient", 32'(q), 32'hFFFF);
        check("ignore.remainder", 32'(r), 32'd0);

        // Asynchronous reset in the middle of a divide.
        start    = 1'b1;
        Dividend = 16'd1000;
        Divisor  = 16'd10;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge Clk); #1;
        end
        check("midreset.busy_before", 32'(busy), 32'd1);
        Reset_n = 1'b0;
        #1;
        $display("midreset: busy=%0b done=%0b Q=0x%0h R=0x%0h dbz=%0b", busy, done, Quotient, Remainder, div_by_zero);
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.done", 32'(done), 32'd0);
        check("midreset.quotient", 32'(Quotient), 32'd0);
        check("midreset.remainder", 32'(Remainder), 32'd0);
        check("midreset.dbz", 32'(div_by_zero), 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        do_txn("after_reset", 16'd50, 16'd7, 16'd7, 16'd1, 1'b0);

        // Back-to-back: next start issued in the first divide's done cycle.
        run_div(16'd3, 16'd10, q, r, z, lat, bc);
        $display("b2b_first: Q=%0d R=%0d lat=%0d", q, r, lat);
        check("b2b_first.quotient", 32'(q), 32'd0);
        check("b2b_first.remainder", 32'(r), 32'd3);
        check("b2b_first.done", 32'(done), 32'd1);
        do_txn("b2b_second", 16'd255, 16'd16, 16'd15, 16'd15, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            model(a, b, eq, er, ez);
            do_txn($sformatf("rand%0d", i), a, b, eq, er, ez);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
